axi4_lite_sram_slave: RTL and testbench
=======================================

// Module: axi4_lite_sram_slave
// PURPOSE
// - AXI4-Lite responder (slave) with a word-addressed, byte-strobed internal SRAM.
// - Terminates the five AXI4-Lite channels driven by the core's AXI4-Lite master.
// - Stands in for DPI memory during RTL simulation and serves as on-chip scratch RAM.
// - Read and write channels are independent; a programmable response latency exercises master stall paths.
// PARAMETERS
// - MEM_DEPTH  1024          number of DATA_WIDTH-bit words (power of 2)
// - BASE_ADDR  32'h8000_0000 byte address of word 0
// - RD_LATENCY 1             cycles from AR handshake to r_valid (>=1)
// - WR_LATENCY 1             cycles from last of AW/W handshake to b_valid (>=1)
// PORTS
// - iClock               in   1                clock; all logic on rising edge
// - iReset               in   1                synchronous, active-high reset
// - pAXI4S_ar_valid      in   1                read address valid
// - pAXI4S_ar_bits_addr  in   DATA_WIDTH       read byte address
// - pAXI4S_ar_ready      out  1                read address accepted
// - pAXI4S_r_valid       out  1                read data valid
// - pAXI4S_r_bits_data   out  DATA_WIDTH       read data
// - pAXI4S_r_bits_resp   out  RESP_WIDTH       read response
// - pAXI4S_r_ready       in   1                master accepts read data
// - pAXI4S_aw_valid      in   1                write address valid
// - pAXI4S_aw_bits_addr  in   DATA_WIDTH       write byte address
// - pAXI4S_aw_ready      out  1                write address accepted
// - pAXI4S_w_valid       in   1                write data valid
// - pAXI4S_w_bits_data   in   DATA_WIDTH       write data
// - pAXI4S_w_bits_strb   in   DATA_WIDTH/8     byte enables
// - pAXI4S_w_ready       out  1                write data accepted
// - pAXI4S_b_valid       out  1                write response valid
// - pAXI4S_b_bits_resp   out  RESP_WIDTH       write response
// - pAXI4S_b_ready       in   1                master accepts write response
// BEHAVIOUR
// - Reset: all valids 0, all readies 0 while iReset=1, resp=OKAY, r_data=0, counters 0, both FSMs IDLE.
// - Memory contents are not reset.
// - Read FSM: R_IDLE -> R_WAIT -> R_RESP.
//   - R_IDLE: ar_ready=1. On ar_valid, latch addr; go to R_WAIT with cnt=RD_LATENCY-1, or straight to R_RESP if RD_LATENCY=1.
//   - R_WAIT: count down; go to R_RESP when cnt=0.
//   - Entering R_RESP: sample memory and drive r_valid=1 from the next cycle.
//   - Min AR-to-r_valid latency = RD_LATENCY cycles.
//   - R_RESP: r_valid, data and resp held stable until r_ready; on handshake go to R_IDLE (ar_ready=1 the next cycle).
//   - At most one outstanding read.
// - Write FSM: W_IDLE -> W_WAIT -> W_RESP.
//   - W_IDLE: aw_ready=!aw_got, w_ready=!w_got; AW and W are accepted in any order or the same cycle, each latched once.
//   - When both are held: go to W_WAIT, count WR_LATENCY-1, then commit the write on entry to W_RESP.
//   - W_RESP: b_valid held until b_ready, then clear aw_got/w_got and return to W_IDLE.
// - Decode: idx = (addr-BASE_ADDR) >> log2(DATA_WIDTH/8).
//   - Out of range (addr<BASE_ADDR or idx>=MEM_DEPTH): resp=DECERR (2'b11), r_data=0, no write.
//   - addr[log2(DATA_WIDTH/8)-1:0]!=0: resp=SLVERR (2'b10), r_data=0, no write.
//   - Otherwise resp=OKAY (2'b00).
// - Write strobe: byte i updated only when strb[i]=1; strb=0 is OKAY and leaves memory unchanged.
// - Same-cycle read sample and write commit to one word: the read returns the OLD data.
// - Reset mid-transaction: the pending transaction is discarded; the master must reissue.
// - Master dropping valid before ready violates protocol; behaviour is not defined and is not tested.
// STRUCTURE
// - Config.v holds DATA_WIDTH, RESP_WIDTH and `AXI4_RESP_OKAY/`AXI4_RESP_SLVERR/`AXI4_RESP_DECERR.
// - Config.v also holds the FSM state encodings `AXI4S_R_* / `AXI4S_W_*.
// - Sub-module sram_byte_we: one read port (comb read, sampled by parent) and one write port with per-byte enable, depth MEM_DEPTH.
// - Top holds the two FSMs, latency counters and address decode.
// TESTING
// - Write 0x8000_0010 data 0xDEADBEEF strb 0xF, then read it: b_resp=OKAY; r_data=0xDEADBEEF, OKAY, r_valid exactly RD_LATENCY cycles after AR.
// - W issued 3 cycles before AW, strb 0x3, data 0x1234_5678 over 0xDEADBEEF: read returns 0xDEAD5678; b_valid only after both handshakes.
// - Read 0x7FFF_FFFC and 0x8000_0000+4*MEM_DEPTH: r_resp=DECERR, r_data=0; write to the same addresses gives b_resp=DECERR and memory unchanged.
// - Read 0x8000_0002: SLVERR; write 0x8000_0001: SLVERR, no memory change.
// - r_ready held low 5 cycles: r_valid/data/resp stable, ar_ready=0; a concurrent write completes independently.
// - iReset asserted while in R_WAIT and W_WAIT: next cycle all valids/readies 0; after release ar/aw/w_ready=1 and no stale r/b response.

Source files
------------

// File: rtl/axi4_lite_sram_slave_pkg.sv
// Shared widths, response codes, FSM encodings and the address decode helper
// for the AXI4-Lite SRAM responder.
package axi4_lite_sram_slave_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int RESP_WIDTH = 2;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(STRB_WIDTH);
    localparam int CNT_WIDTH  = 8;

    localparam logic [RESP_WIDTH-1:0] AXI4_RESP_OKAY   = 2'b00;
    localparam logic [RESP_WIDTH-1:0] AXI4_RESP_SLVERR = 2'b10;
    localparam logic [RESP_WIDTH-1:0] AXI4_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    // Out-of-range takes priority over misalignment.
    function automatic logic [RESP_WIDTH-1:0] decode_resp(
        input logic [DATA_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] base,
        input logic [DATA_WIDTH-1:0] depth
    );
        logic [DATA_WIDTH-1:0] off;
        logic [RESP_WIDTH-1:0] resp;
        off = addr - base;
        if (addr < base) begin
            resp = AXI4_RESP_DECERR;
        end else if ((off >> BYTE_SHIFT) >= depth) begin
            resp = AXI4_RESP_DECERR;
        end else if (addr[BYTE_SHIFT-1:0] != {BYTE_SHIFT{1'b0}}) begin
            resp = AXI4_RESP_SLVERR;
        end else begin
            resp = AXI4_RESP_OKAY;
        end
        return resp;
    endfunction

endpackage

// File: rtl/axi4_lite_sram_slave_sram_byte_we.sv
// Word-organised SRAM with a combinational read port and a byte-enabled
// synchronous write port. Contents are never reset.
module sram_byte_we
    import axi4_lite_sram_slave_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [STRB_WIDTH-1:0] wr_strb
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    assign rd_data = mem_r[rd_idx];

    // Byte-lane write: only lanes with their strobe set are updated.
    always_ff @(posedge clk) begin
        for (int b = 0; b < STRB_WIDTH; b++) begin
            if (wr_en && wr_strb[b]) begin
                mem_r[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/axi4_lite_sram_slave.sv
// AXI4-Lite responder backed by a byte-strobed SRAM; independent read and
// write FSMs, each with a programmable response latency.
module axi4_lite_sram_slave
    import axi4_lite_sram_slave_pkg::*;
#(
    parameter int              MEM_DEPTH  = 1024,
    parameter logic [31:0]     BASE_ADDR  = 32'h8000_0000,
    parameter int              RD_LATENCY = 1,
    parameter int              WR_LATENCY = 1
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  pAXI4S_ar_valid,
    input  logic [DATA_WIDTH-1:0] pAXI4S_ar_bits_addr,
    output logic                  pAXI4S_ar_ready,
    output logic                  pAXI4S_r_valid,
    output logic [DATA_WIDTH-1:0] pAXI4S_r_bits_data,
    output logic [RESP_WIDTH-1:0] pAXI4S_r_bits_resp,
    input  logic                  pAXI4S_r_ready,
    input  logic                  pAXI4S_aw_valid,
    input  logic [DATA_WIDTH-1:0] pAXI4S_aw_bits_addr,
    output logic                  pAXI4S_aw_ready,
    input  logic                  pAXI4S_w_valid,
    input  logic [DATA_WIDTH-1:0] pAXI4S_w_bits_data,
    input  logic [STRB_WIDTH-1:0] pAXI4S_w_bits_strb,
    output logic                  pAXI4S_w_ready,
    output logic                  pAXI4S_b_valid,
    output logic [RESP_WIDTH-1:0] pAXI4S_b_bits_resp,
    input  logic                  pAXI4S_b_ready
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [CNT_WIDTH-1:0] RD_LOAD = CNT_WIDTH'(RD_LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] WR_LOAD = CNT_WIDTH'(WR_LATENCY - 1);
    localparam bit RD_DIRECT = (RD_LATENCY <= 32'sd1);
    localparam bit WR_DIRECT = (WR_LATENCY <= 32'sd1);

    r_state_e               r_state_r, r_state_s;
    logic [CNT_WIDTH-1:0]   r_cnt_r, r_cnt_s;
    logic [DATA_WIDTH-1:0]  ar_addr_r;
    logic                   ar_ready_r, r_valid_r;
    logic [DATA_WIDTH-1:0]  r_data_r;
    logic [RESP_WIDTH-1:0]  r_resp_r;

    w_state_e               w_state_r, w_state_s;
    logic [CNT_WIDTH-1:0]   w_cnt_r, w_cnt_s;
    logic [DATA_WIDTH-1:0]  aw_addr_r, w_data_r;
    logic [STRB_WIDTH-1:0]  w_strb_r;
    logic                   aw_got_r, w_got_r, aw_got_s, w_got_s;
    logic                   aw_ready_r, w_ready_r, b_valid_r;
    logic [RESP_WIDTH-1:0]  b_resp_r;

    logic                   ar_hs_s, r_hs_s, aw_hs_s, w_hs_s, b_hs_s;
    logic [RESP_WIDTH-1:0]  rd_resp_s, wr_resp_s;
    logic [IDX_W-1:0]       rd_idx_s, wr_idx_s;
    logic [DATA_WIDTH-1:0]  rd_data_s;
    logic                   wr_en_s, r_sample_s;

    assign ar_hs_s = pAXI4S_ar_valid & ar_ready_r;
    assign r_hs_s  = r_valid_r & pAXI4S_r_ready;
    assign aw_hs_s = pAXI4S_aw_valid & aw_ready_r;
    assign w_hs_s  = pAXI4S_w_valid & w_ready_r;
    assign b_hs_s  = b_valid_r & pAXI4S_b_ready;

    assign rd_resp_s = decode_resp(ar_addr_r, BASE_ADDR, 32'(MEM_DEPTH));
    assign wr_resp_s = decode_resp(aw_addr_r, BASE_ADDR, 32'(MEM_DEPTH));
    assign rd_idx_s  = IDX_W'((ar_addr_r - BASE_ADDR) >> BYTE_SHIFT);
    assign wr_idx_s  = IDX_W'((aw_addr_r - BASE_ADDR) >> BYTE_SHIFT);

    // The first R_RESP/W_RESP cycle (valid still low) is the sample/commit slot.
    assign r_sample_s = (r_state_r == R_RESP) && !r_valid_r;
    assign wr_en_s    = (w_state_r == W_RESP) && !b_valid_r && (wr_resp_s == AXI4_RESP_OKAY);

    sram_byte_we #(.DEPTH(MEM_DEPTH)) u_sram (
        .clk     (iClock),
        .rd_idx  (rd_idx_s),
        .rd_data (rd_data_s),
        .wr_en   (wr_en_s),
        .wr_idx  (wr_idx_s),
        .wr_data (w_data_r),
        .wr_strb (w_strb_r)
    );

    // Read FSM next-state and latency countdown.
    always_comb begin
        r_state_s = r_state_r;
        r_cnt_s   = r_cnt_r;
        case (r_state_r)
            R_IDLE: begin
                if (ar_hs_s) begin
                    r_cnt_s   = RD_LOAD;
                    r_state_s = RD_DIRECT ? R_RESP : R_WAIT;
                end else begin
                    r_state_s = R_IDLE;
                end
            end
            R_WAIT: begin
                r_cnt_s = r_cnt_r - 8'd1;
                if (r_cnt_r <= 8'd1) begin
                    r_state_s = R_RESP;
                end else begin
                    r_state_s = R_WAIT;
                end
            end
            R_RESP: begin
                if (r_hs_s) begin
                    r_state_s = R_IDLE;
                end else begin
                    r_state_s = R_RESP;
                end
            end
            default: begin
                r_state_s = R_IDLE;
                r_cnt_s   = 8'd0;
            end
        endcase
    end

    // Read state, address latch and registered R channel.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_state_r  <= R_IDLE;
            r_cnt_r    <= 8'd0;
            ar_addr_r  <= 32'd0;
            ar_ready_r <= 1'b0;
            r_valid_r  <= 1'b0;
            r_data_r   <= 32'd0;
            r_resp_r   <= AXI4_RESP_OKAY;
        end else begin
            r_state_r  <= r_state_s;
            r_cnt_r    <= r_cnt_s;
            ar_ready_r <= (r_state_s == R_IDLE);
            if (ar_hs_s) begin
                ar_addr_r <= pAXI4S_ar_bits_addr;
            end
            if (r_sample_s) begin
                r_valid_r <= 1'b1;
                r_resp_r  <= rd_resp_s;
                r_data_r  <= (rd_resp_s == AXI4_RESP_OKAY) ? rd_data_s : 32'd0;
            end else if (r_hs_s) begin
                r_valid_r <= 1'b0;
            end
        end
    end

    // Write FSM next-state: collect AW and W in any order, then count down.
    always_comb begin
        w_state_s = w_state_r;
        w_cnt_s   = w_cnt_r;
        aw_got_s  = aw_got_r;
        w_got_s   = w_got_r;
        case (w_state_r)
            W_IDLE: begin
                aw_got_s = aw_got_r | aw_hs_s;
                w_got_s  = w_got_r | w_hs_s;
                if (aw_got_s && w_got_s) begin
                    w_cnt_s   = WR_LOAD;
                    w_state_s = WR_DIRECT ? W_RESP : W_WAIT;
                end else begin
                    w_state_s = W_IDLE;
                end
            end
            W_WAIT: begin
                w_cnt_s = w_cnt_r - 8'd1;
                if (w_cnt_r <= 8'd1) begin
                    w_state_s = W_RESP;
                end else begin
                    w_state_s = W_WAIT;
                end
            end
            W_RESP: begin
                if (b_hs_s) begin
                    aw_got_s  = 1'b0;
                    w_got_s   = 1'b0;
                    w_state_s = W_IDLE;
                end else begin
                    w_state_s = W_RESP;
                end
            end
            default: begin
                aw_got_s  = 1'b0;
                w_got_s   = 1'b0;
                w_cnt_s   = 8'd0;
                w_state_s = W_IDLE;
            end
        endcase
    end

    // Write state, AW/W latches and registered B channel.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            w_state_r  <= W_IDLE;
            w_cnt_r    <= 8'd0;
            aw_addr_r  <= 32'd0;
            w_data_r   <= 32'd0;
            w_strb_r   <= 4'd0;
            aw_got_r   <= 1'b0;
            w_got_r    <= 1'b0;
            aw_ready_r <= 1'b0;
            w_ready_r  <= 1'b0;
            b_valid_r  <= 1'b0;
            b_resp_r   <= AXI4_RESP_OKAY;
        end else begin
            w_state_r  <= w_state_s;
            w_cnt_r    <= w_cnt_s;
            aw_got_r   <= aw_got_s;
            w_got_r    <= w_got_s;
            aw_ready_r <= (w_state_s == W_IDLE) && !aw_got_s;
            w_ready_r  <= (w_state_s == W_IDLE) && !w_got_s;
            if (aw_hs_s) begin
                aw_addr_r <= pAXI4S_aw_bits_addr;
            end
            if (w_hs_s) begin
                w_data_r <= pAXI4S_w_bits_data;
                w_strb_r <= pAXI4S_w_bits_strb;
            end
            if ((w_state_r == W_RESP) && !b_valid_r) begin
                b_valid_r <= 1'b1;
                b_resp_r  <= wr_resp_s;
            end else if (b_hs_s) begin
                b_valid_r <= 1'b0;
            end
        end
    end

    assign pAXI4S_ar_ready    = ar_ready_r;
    assign pAXI4S_r_valid     = r_valid_r;
    assign pAXI4S_r_bits_data = r_data_r;
    assign pAXI4S_r_bits_resp = r_resp_r;
    assign pAXI4S_aw_ready    = aw_ready_r;
    assign pAXI4S_w_ready     = w_ready_r;
    assign pAXI4S_b_valid     = b_valid_r;
    assign pAXI4S_b_bits_resp = b_resp_r;

endmodule

// File: tb/tb_axi4_lite_sram_slave.sv
// Randomized bench for axi4_lite_sram_slave against a word-array reference
// model of the memory and of the address decode rules.
module tb_axi4_lite_sram_slave;

    localparam int          DEPTH  = 1024;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          RD_LAT = 3;
    localparam int          WR_LAT = 2;
    localparam int          REGION = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        ar_valid, ar_ready, r_valid, r_ready;
    logic [31:0] ar_addr, r_data;
    logic [1:0]  r_resp, b_resp;
    logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic [31:0] aw_addr, w_data;
    logic [3:0]  w_strb;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] mem_m [DEPTH];

    axi4_lite_sram_slave #(
        .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE), .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)
    ) dut (
        .iClock(clk), .iReset(rst),
        .pAXI4S_ar_valid(ar_valid), .pAXI4S_ar_bits_addr(ar_addr), .pAXI4S_ar_ready(ar_ready),
        .pAXI4S_r_valid(r_valid), .pAXI4S_r_bits_data(r_data), .pAXI4S_r_bits_resp(r_resp),
        .pAXI4S_r_ready(r_ready),
        .pAXI4S_aw_valid(aw_valid), .pAXI4S_aw_bits_addr(aw_addr), .pAXI4S_aw_ready(aw_ready),
        .pAXI4S_w_valid(w_valid), .pAXI4S_w_bits_data(w_data), .pAXI4S_w_bits_strb(w_strb),
        .pAXI4S_w_ready(w_ready),
        .pAXI4S_b_valid(b_valid), .pAXI4S_b_bits_resp(b_resp), .pAXI4S_b_ready(b_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Decode rules evaluated in signed 64-bit byte offsets.
    function automatic logic [1:0] model_resp(input logic [31:0] addr);
        longint off;
        off = $signed({32'd0, addr}) - $signed({32'd0, BASE});
        if (off < 0 || off >= 4 * DEPTH) return 2'b11;
        if (off % 4 != 0) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [31:0] addr);
        if (model_resp(addr) != 2'b00) return 32'd0;
        return mem_m[(addr - BASE) / 4];
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb);
        int idx;
        if (model_resp(addr) == 2'b00) begin
            idx = int'((addr - BASE) / 4);
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mem_m[idx][8*b +: 8] = data[8*b +: 8];
            end
        end
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_delay, input int w_delay, input int b_delay, input string tag);
        bit aw_done = 1'b0, w_done = 1'b0, will_aw, will_w, early_b = 1'b0;
        int cyc = 0, lat = 0;
        logic [1:0] exp_resp;
        exp_resp = model_resp(addr);
        while (!(aw_done && w_done) && cyc < 40) begin
            aw_valid = !aw_done && (cyc >= aw_delay);
            aw_addr  = addr;
            w_valid  = !w_done && (cyc >= w_delay);
            w_data   = data;
            w_strb   = strb;
            will_aw  = aw_valid && aw_ready;
            will_w   = w_valid && w_ready;
            if (b_valid) early_b = 1'b1;
            @(posedge clk); #1;
            cyc++;
            if (will_aw) aw_done = 1'b1;
            if (will_w) w_done = 1'b1;
        end
        aw_valid = 1'b0;
        w_valid  = 1'b0;
        check_eq({tag, "_hs"}, {30'd0, aw_done, w_done}, 32'd3);
        check_eq({tag, "_early_b"}, {31'd0, early_b}, 32'd0);
        while (!b_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_b_lat"}, lat, WR_LAT);
        check_eq({tag, "_b_resp"}, {30'd0, b_resp}, {30'd0, exp_resp});
        for (int i = 0; i < b_delay; i++) begin
            @(posedge clk); #1;
            check_eq({tag, "_b_hold"}, {31'd0, b_valid}, 32'd1);
        end
        b_ready = 1'b1;
        @(posedge clk); #1;
        b_ready = 1'b0;
        check_eq({tag, "_b_clr"}, {29'd0, b_valid, aw_ready, w_ready}, 32'd3);
        model_write(addr, data, strb);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int r_delay, input string tag);
        bit done = 1'b0, will_ar;
        int cyc = 0, lat = 0;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        exp_data = model_rdata(addr);
        exp_resp = model_resp(addr);
        while (!done && cyc < 40) begin
            ar_valid = 1'b1;
            ar_addr  = addr;
            will_ar  = ar_valid && ar_ready;
            @(posedge clk); #1;
            cyc++;
            if (will_ar) done = 1'b1;
        end
        ar_valid = 1'b0;
        check_eq({tag, "_ar_hs"}, {31'd0, done}, 32'd1);
        while (!r_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_r_lat"}, lat, RD_LAT);
        for (int i = 0; i < r_delay; i++) begin
            @(posedge clk); #1;
            check_eq({tag, "_hold_v"}, {30'd0, r_valid, ar_ready}, 32'd2);
            check_eq({tag, "_hold_d"}, r_data, exp_data);
            check_eq({tag, "_hold_r"}, {30'd0, r_resp}, {30'd0, exp_resp});
        end
        check_eq({tag, "_data"}, r_data, exp_data);
        check_eq({tag, "_resp"}, {30'd0, r_resp}, {30'd0, exp_resp});
        r_ready = 1'b1;
        @(posedge clk); #1;
        r_ready = 1'b0;
        check_eq({tag, "_r_clr"}, {30'd0, r_valid, ar_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] addr;
        bit stale;
        rst = 1'b1;
        ar_valid = 1'b0; ar_addr = 32'd0; r_ready = 1'b0;
        aw_valid = 1'b0; aw_addr = 32'd0; w_valid = 1'b0; w_data = 32'd0; w_strb = 4'd0;
        b_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ctl", {27'd0, r_valid, b_valid, ar_ready, aw_ready, w_ready}, 32'd0);
        check_eq("rst_rdata", r_data, 32'd0);
        check_eq("rst_resp", {28'd0, r_resp, b_resp}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("rel_ready", {29'd0, ar_ready, aw_ready, w_ready}, 32'd7);

        for (int i = 0; i < REGION; i++) begin
            axi_write(BASE + 32'(4 * i), $urandom, 4'hF, 0, 0, 0, "init");
        end
        axi_write(BASE + 32'(4 * (DEPTH - 1)), $urandom, 4'hF, 0, 0, 0, "init_top");

        axi_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, "wr_beef");
        axi_read(32'h8000_0010, 0, "rd_beef");
        axi_write(32'h8000_0010, 32'h1234_5678, 4'h3, 3, 0, 1, "w_first");
        axi_read(32'h8000_0010, 0, "rd_merge");

        axi_read(32'h7FFF_FFFC, 0, "rd_below");
        axi_read(BASE + 32'(4 * DEPTH), 0, "rd_above");
        axi_write(32'h7FFF_FFFC, 32'hA5A5_A5A5, 4'hF, 0, 0, 0, "wr_below");
        axi_write(BASE + 32'(4 * DEPTH), 32'h5A5A_5A5A, 4'hF, 0, 0, 0, "wr_above");
        axi_read(BASE, 0, "rd_w0_kept");
        axi_read(BASE + 32'(4 * (DEPTH - 1)), 0, "rd_top_kept");
        axi_read(32'h8000_0002, 0, "rd_slverr");
        axi_write(32'h8000_0001, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, "wr_slverr");
        axi_read(32'h8000_0000, 0, "rd_w0_kept2");

        fork
            axi_read(32'h8000_0008, 5, "stall");
            axi_write(32'h8000_000C, 32'h0BAD_CAFE, 4'hF, 1, 1, 0, "conc");
        join
        axi_read(32'h8000_000C, 0, "rd_conc");

        // Reset while both FSMs are counting down.
        ar_valid = 1'b1; ar_addr = 32'h8000_0014;
        aw_valid = 1'b1; aw_addr = 32'h8000_0014;
        w_valid = 1'b1; w_data = 32'hCAFE_F00D; w_strb = 4'hF;
        check_eq("mid_pre", {29'd0, ar_ready, aw_ready, w_ready}, 32'd7);
        @(posedge clk); #1;
        ar_valid = 1'b0; aw_valid = 1'b0; w_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("mid_rst", {27'd0, r_valid, b_valid, ar_ready, aw_ready, w_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_rel", {29'd0, ar_ready, aw_ready, w_ready}, 32'd7);
        stale = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (r_valid || b_valid) stale = 1'b1;
        end
        check_eq("mid_stale", {31'd0, stale}, 32'd0);
        axi_read(32'h8000_0014, 0, "rd_discard");

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0:       addr = BASE - 32'(4 * $urandom_range(1, 8));
                1:       addr = BASE + 32'(4 * (DEPTH + $urandom_range(0, 8)));
                2:       addr = BASE + 32'(4 * $urandom_range(0, REGION - 1)) + 32'($urandom_range(1, 3));
                default: addr = BASE + 32'(4 * $urandom_range(0, REGION - 1));
            endcase
            if ($urandom_range(0, 1) == 0) begin
                axi_write(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 2), "rnd_wr");
            end else begin
                axi_read(addr, $urandom_range(0, 3), "rnd_rd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
